mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Third pipeline stage, directly downstream of the decode/execute stage.
- Consumes that stage's registered outputs: PC, ALU result, forwarded rs2 data, instruction.
- Performs data-memory load/store over a req/ready handshake, formats load data, selects writeback data, and drives reg_wr/wdata back into the register file.
- Raises stall while a memory access is outstanding, which freezes the upstream pipeline registers.

Parameters:
TIMEOUT, 255, max cycles in WAIT before the access is aborted; 0 disables the timeout.

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
PC_ppl  input  32  PC of the instruction in this stage
ALU_ppl  input  32  ALU result; effective address for loads/stores
rdata2_ppl  input  32  store data (rs2)
instruction_ppl  input  32  instruction in this stage; 32'h0 is a bubble
dmem_rdata  input  32  read data, valid when dmem_ready=1
dmem_ready  input  1  memory accepts/completes the request this cycle
dmem_req  output  1  memory request
dmem_we  output  1  1=store, 0=load
dmem_addr  output  32  word-aligned address {ALU_ppl[31:2],2'b00}
dmem_wdata  output  32  lane-replicated store data
dmem_be  output  4  byte enables
stall  output  1  hold upstream pipeline registers
reg_wr  output  1  register-file write enable
wdata  output  32  register-file write data
mem_fault  output  1  one-cycle pulse: misaligned, unsupported func3, or timeout

Behaviour:
- Reset: one clock, asynchronous active-high reset.
  - State goes to IDLE; load buffer and timeout counter go to 0; mem_fault goes to 0.
  - Every combinational output (dmem_req, stall, reg_wr) is 0 while rst=1.
- Decode: opcode=instruction_ppl[6:2], func3=[14:12], rd=[11:7].
  - Load=00000, store=01000, JAL=11011, JALR=11001.
  - instruction_ppl==0 is a bubble: no request, no write, no fault.
- Writeback select:
  - Load: formatted load buffer.
  - JAL/JALR: PC_ppl+4.
  - All else: ALU_ppl.
- reg_wr=1 for R(01100), I(00100), LUI(01101), AUIPC(00101), JAL and JALR when rd!=0, in the same cycle as the instruction.
  - Loads write only in DONE.
  - Stores, branches, bubbles and faults never write.
- Alignment:
  - Byte accesses are always aligned.
  - Halfword needs addr[0]=0; word needs addr[1:0]=0.
- Store lanes:
  - SB: be=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}.
  - SH: be=4'b0011<<{addr[1],1'b0}, wdata={2{rs2[15:0]}}.
  - SW: be=4'hF, wdata=rs2.
  - Loads drive be=4'hF.
- Load format (func3, buffer lane by addr[1:0]):
  - 000 LB and 100 LBU: sign-/zero-extend the selected byte.
  - 001 LH and 101 LHU: sign-/zero-extend the selected halfword.
  - 010 LW: full word.
  - Loads with 011/110/111 and stores with func3>010 are unsupported.
- FSM (IDLE, WAIT, DONE):
  - IDLE, memory op, aligned, supported: dmem_req=1, stall=1, counter cleared.
    - dmem_ready=1 → capture dmem_rdata into the buffer, go to DONE.
    - Otherwise go to WAIT.
  - IDLE, faulting memory op: no request, stall=0, mem_fault pulses one cycle, no write. The instruction retires as a bubble and the state stays IDLE.
  - WAIT: dmem_req=1, stall=1, address/data/be held stable. Counter increments each cycle.
    - dmem_ready=1 → capture, go to DONE.
    - TIMEOUT!=0 and counter==TIMEOUT-1 with no ready → drop req, pulse mem_fault, go to IDLE with stall=0 and no write.
    - Ready wins over timeout in the same cycle.
  - DONE: dmem_req=0, stall=0. A load writes the buffer (reg_wr=1 if rd!=0); a store writes nothing. Next state IDLE.
- Latency: a memory op costs at least 2 cycles (request + DONE); non-memory ops cost 1 cycle with stall=0.
- Reset during WAIT: dmem_req drops immediately; the access is abandoned with no write.
- The stage never reads dmem_rdata outside a ready cycle.

Test Plan:
- ALU op: ADDI x5 (instruction 32'h00A00293), ALU_ppl=10 → reg_wr=1, wdata=10, stall=0 same cycle, dmem_req=0.
- Zero-wait load: LB x6,0(x0) with ALU_ppl=32'h103, dmem_ready=1 in the first cycle, dmem_rdata=32'h80FF_FF7F → cycle 1: req=1, stall=1, addr=32'h100. Cycle 2: reg_wr=1, wdata=32'hFFFF_FF80, stall=0.
- Wait-state store: SH with ALU_ppl=32'h202, rs2=32'h1234_ABCD, ready after 3 cycles → be=4'b1100, wdata=32'hABCD_ABCD held for all 4 req cycles, then DONE with reg_wr=0.
- Misaligned LW at 32'h101 → dmem_req never asserted, mem_fault=1 for exactly one cycle, reg_wr=0, stall=0.
- Timeout with TIMEOUT=4 and a load that never gets ready → req high for 4 cycles, then mem_fault pulse, stall=0, no write, next load proceeds normally.
- Bubble (instruction 0), then rst asserted during WAIT → bubble: no req, no write; reset: req/stall drop asynchronously, FSM in IDLE after release, no write.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory / writeback stage.
// Issues data-memory loads and stores over a req/ready handshake, formats
// load data, selects register writeback data and stalls upstream while an
// access is outstanding.
//
//  state | meaning
//  ------+----------------------------------------------------------------
//  IDLE  | no access in flight; ALU/jump ops retire, memory ops are issued
//  WAIT  | request outstanding, memory has not answered yet
//  DONE  | memory answered; loads write back from the captured buffer
module mem_wb_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC_ppl,
    input  logic [31:0] ALU_ppl,
    input  logic [31:0] rdata2_ppl,
    input  logic [31:0] instruction_ppl,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    output logic        stall,
    output logic        reg_wr,
    output logic [31:0] wdata,
    output logic        mem_fault
);

    // Counter only needs to reach TIMEOUT-1.
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_STORE = 5'b01000;
    localparam logic [4:0] OP_JAL   = 5'b11011;
    localparam logic [4:0] OP_JALR  = 5'b11001;
    localparam logic [4:0] OP_R     = 5'b01100;
    localparam logic [4:0] OP_I     = 5'b00100;
    localparam logic [4:0] OP_LUI   = 5'b01101;
    localparam logic [4:0] OP_AUIPC = 5'b00101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      buf_q, buf_d;

    logic [4:0]  opcode;
    logic [2:0]  func3;
    logic [4:0]  rd;
    logic        is_bubble;
    logic        is_load;
    logic        is_store;
    logic        is_mem;
    logic        is_jump;
    logic        is_alu_wr;
    logic        rd_nz;
    logic        misaligned;
    logic        unsupported;
    logic        mem_ok;
    logic        mem_bad;
    logic        timeout_hit;

    logic        req_c;
    logic        stall_c;
    logic        wr_c;
    logic        fault_c;

    logic [31:0] load_fmt;
    logic [3:0]  be_c;
    logic [31:0] st_data_c;

    // Instruction field decode and classification.
    always_comb begin
        opcode    = instruction_ppl[6:2];
        func3     = instruction_ppl[14:12];
        rd        = instruction_ppl[11:7];
        // An all-zero word decodes as a load opcode, so bubbles are
        // excluded explicitly from every class.
        is_bubble = (instruction_ppl == 32'h0);
        is_load   = !is_bubble && (opcode == OP_LOAD);
        is_store  = !is_bubble && (opcode == OP_STORE);
        is_mem    = is_load || is_store;
        is_jump   = !is_bubble && ((opcode == OP_JAL) || (opcode == OP_JALR));
        is_alu_wr = !is_bubble && ((opcode == OP_R)   || (opcode == OP_I)   ||
                                   (opcode == OP_LUI) || (opcode == OP_AUIPC) ||
                                   (opcode == OP_JAL) || (opcode == OP_JALR));
        rd_nz     = (rd != 5'd0);
    end

    // Alignment and func3 legality for memory ops.
    always_comb begin
        misaligned = 1'b0;
        case (func3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = ALU_ppl[0];
            2'b10:   misaligned = (ALU_ppl[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase

        unsupported = 1'b0;
        if (is_load) begin
            unsupported = (func3 == 3'b011) || (func3 == 3'b110) ||
                          (func3 == 3'b111);
        end else if (is_store) begin
            unsupported = (func3 > 3'b010);
        end

        mem_ok      = is_mem && !misaligned && !unsupported;
        mem_bad     = is_mem && (misaligned || unsupported);
        timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    end

    // Store lane steering; loads always enable the whole word.
    always_comb begin
        be_c      = 4'hF;
        st_data_c = rdata2_ppl;
        if (is_store) begin
            case (func3[1:0])
                2'b00: begin
                    be_c      = 4'b0001 << ALU_ppl[1:0];
                    st_data_c = {4{rdata2_ppl[7:0]}};
                end
                2'b01: begin
                    be_c      = 4'b0011 << {ALU_ppl[1], 1'b0};
                    st_data_c = {2{rdata2_ppl[15:0]}};
                end
                default: begin
                    be_c      = 4'hF;
                    st_data_c = rdata2_ppl;
                end
            endcase
        end
    end

    // Load data formatting from the captured buffer.
    always_comb begin
        logic [7:0]  sel_b;
        logic [15:0] sel_h;
        sel_b = 8'h0;
        case (ALU_ppl[1:0])
            2'b00:   sel_b = buf_q[7:0];
            2'b01:   sel_b = buf_q[15:8];
            2'b10:   sel_b = buf_q[23:16];
            default: sel_b = buf_q[31:24];
        endcase
        sel_h = ALU_ppl[1] ? buf_q[31:16] : buf_q[15:0];

        load_fmt = buf_q;
        case (func3)
            3'b000:  load_fmt = {{24{sel_b[7]}}, sel_b};
            3'b100:  load_fmt = {24'h0, sel_b};
            3'b001:  load_fmt = {{16{sel_h[15]}}, sel_h};
            3'b101:  load_fmt = {16'h0, sel_h};
            default: load_fmt = buf_q;
        endcase
    end

    // Sequencing: next state, timeout counter, load buffer and handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        req_c   = 1'b0;
        stall_c = 1'b0;
        wr_c    = 1'b0;
        fault_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mem_ok) begin
                    req_c   = 1'b1;
                    stall_c = 1'b1;
                    cnt_d   = '0;
                    if (dmem_ready) begin
                        buf_d   = dmem_rdata;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (mem_bad) begin
                    // Faulting access retires as a bubble without stalling.
                    fault_c = 1'b1;
                end else if (is_alu_wr && rd_nz) begin
                    wr_c = 1'b1;
                end
            end

            S_WAIT: begin
                if (dmem_ready) begin
                    // A late answer still wins over the timeout.
                    req_c   = 1'b1;
                    stall_c = 1'b1;
                    buf_d   = dmem_rdata;
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    fault_c = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    req_c   = 1'b1;
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end

            S_DONE: begin
                wr_c    = is_load && rd_nz;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counter and load buffer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            buf_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    // Outputs; control strobes are forced low for the whole reset window.
    always_comb begin
        dmem_req   = req_c   && !rst;
        stall      = stall_c && !rst;
        reg_wr     = wr_c    && !rst;
        mem_fault  = fault_c && !rst;
        dmem_we    = is_store;
        dmem_addr  = {ALU_ppl[31:2], 2'b00};
        dmem_wdata = st_data_c;
        dmem_be    = be_c;
        if (is_load)
            wdata = load_fmt;
        else if (is_jump)
            wdata = PC_ppl + 32'd4;
        else
            wdata = ALU_ppl;
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with a writeback scoreboard.
module tb_mem_wb_stage;

    logic        clk;
    logic        rst;
    logic [31:0] PC_ppl;
    logic [31:0] ALU_ppl;
    logic [31:0] rdata2_ppl;
    logic [31:0] instruction_ppl;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        stall;
    logic        reg_wr;
    logic [31:0] wdata;
    logic        mem_fault;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb_q[$];

    mem_wb_stage #(.TIMEOUT(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .PC_ppl          (PC_ppl),
        .ALU_ppl         (ALU_ppl),
        .rdata2_ppl      (rdata2_ppl),
        .instruction_ppl (instruction_ppl),
        .dmem_rdata      (dmem_rdata),
        .dmem_ready      (dmem_ready),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .dmem_be         (dmem_be),
        .stall           (stall),
        .reg_wr          (reg_wr),
        .wdata           (wdata),
        .mem_fault       (mem_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Sample at the falling edge and retire any register write against the scoreboard.
    task automatic sample();
        @(negedge clk);
        if (reg_wr === 1'b1) begin
            if (sb_q.size() == 0)
                chk("unexpected_write", {31'h0, reg_wr}, 32'h0);
            else
                chk("wb_data", wdata, sb_q.pop_front());
        end
        chk("missed_write", 32'(sb_q.size()), 32'h0);
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] alu, input logic [31:0] rs2,
                         input logic rdy, input logic [31:0] rdat);
        instruction_ppl = instr;
        PC_ppl          = pc;
        ALU_ppl         = alu;
        rdata2_ppl      = rs2;
        dmem_ready      = rdy;
        dmem_rdata      = rdat;
    endtask

    task automatic chk_ctl(input string tag, input logic req, input logic stl,
                           input logic flt);
        chk({tag, "_req"},   {31'h0, dmem_req},  {31'h0, req});
        chk({tag, "_stall"}, {31'h0, stall},     {31'h0, stl});
        chk({tag, "_fault"}, {31'h0, mem_fault}, {31'h0, flt});
    endtask

    // Zero-wait load: request cycle, then DONE writes the formatted value.
    task automatic load0(input string tag, input logic [31:0] instr,
                         input logic [31:0] alu, input logic [31:0] rdat,
                         input logic [31:0] exp);
        next();
        drive(instr, 32'h0, alu, 32'h0, 1'b1, rdat);
        sample();
        chk_ctl({tag, "_c1"}, 1'b1, 1'b1, 1'b0);
        chk({tag, "_addr"}, dmem_addr, {alu[31:2], 2'b00});
        chk({tag, "_be"}, {28'h0, dmem_be}, 32'hF);
        next();
        dmem_ready = 1'b0;
        dmem_rdata = 32'hDEAD_BEEF;
        sb_q.push_back(exp);
        sample();
        chk_ctl({tag, "_c2"}, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        drive(32'h00A0_0293, 32'h0, 32'd10, 32'h0, 1'b0, 32'h0);

        // Reset: strobes low even with a writing instruction presented.
        sample();
        chk_ctl("rst", 1'b0, 1'b0, 1'b0);
        chk("rst_wr", {31'h0, reg_wr}, 32'h0);

        // ADDI x5 retires in one cycle.
        next();
        rst = 1'b0;
        sb_q.push_back(32'd10);
        sample();
        chk_ctl("addi", 1'b0, 1'b0, 1'b0);

        // ADDI x0 must not write.
        next();
        drive(32'h00A0_0013, 32'h0, 32'd33, 32'h0, 1'b0, 32'h0);
        sample();

        // JAL x1 writes PC+4.
        next();
        drive(32'h0000_00EF, 32'h0000_1000, 32'h0000_5555, 32'h0, 1'b0, 32'h0);
        sb_q.push_back(32'h0000_1004);
        sample();

        // Zero-wait loads in various formats.
        load0("lb",  32'h0000_0303, 32'h0000_0103, 32'h80FF_FF7F, 32'hFFFF_FF80);
        load0("lhu", 32'h0000_5503, 32'h0000_0302, 32'h8001_7FFF, 32'h0000_8001);
        load0("lh",  32'h0000_1583, 32'h0000_0300, 32'h1234_F00F, 32'hFFFF_F00F);
        load0("lbu", 32'h0000_4603, 32'h0000_0301, 32'h0000_9A00, 32'h0000_009A);

        // SH with three wait cycles: lanes held across all four request cycles.
        next();
        drive(32'h0000_1023, 32'h0, 32'h0000_0202, 32'h1234_ABCD, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            dmem_ready = (i == 3);
            sample();
            chk_ctl("sh", 1'b1, 1'b1, 1'b0);
            chk("sh_be", {28'h0, dmem_be}, 32'hC);
            chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
            chk("sh_addr", dmem_addr, 32'h0000_0200);
            chk("sh_we", {31'h0, dmem_we}, 32'h1);
            next();
        end
        dmem_ready = 1'b0;
        sample();
        chk_ctl("sh_done", 1'b0, 1'b0, 1'b0);

        // SB at byte 3.
        next();
        drive(32'h0000_0023, 32'h0, 32'h0000_0013, 32'hFFFF_FFA5, 1'b1, 32'h0);
        sample();
        chk_ctl("sb", 1'b1, 1'b1, 1'b0);
        chk("sb_be", {28'h0, dmem_be}, 32'h8);
        chk("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
        next();
        dmem_ready = 1'b0;
        sample();
        chk_ctl("sb_done", 1'b0, 1'b0, 1'b0);

        // Misaligned LW faults for exactly one cycle.
        next();
        drive(32'h0000_2383, 32'h0, 32'h0000_0101, 32'h0, 1'b0, 32'h0);
        sample();
        chk_ctl("mis", 1'b0, 1'b0, 1'b1);
        next();
        drive(32'h0, 32'h0, 32'h0000_0101, 32'h0, 1'b0, 32'h0);
        sample();
        chk_ctl("bubble", 1'b0, 1'b0, 1'b0);

        // Unsupported load func3 011.
        next();
        drive(32'h0000_3003, 32'h0, 32'h0000_0000, 32'h0, 1'b0, 32'h0);
        sample();
        chk_ctl("unsup", 1'b0, 1'b0, 1'b1);

        // Timeout: four request cycles, then a fault cycle with no write.
        next();
        drive(32'h0000_2403, 32'h0, 32'h0000_0040, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            sample();
            chk_ctl("to_wait", 1'b1, 1'b1, 1'b0);
            next();
        end
        sample();
        chk_ctl("to_abort", 1'b0, 1'b0, 1'b1);

        // The next load proceeds normally.
        load0("after_to", 32'h0000_2483, 32'h0000_0044, 32'h55AA_1234, 32'h55AA_1234);

        // Reset in WAIT drops the request immediately and abandons the load.
        next();
        drive(32'h0000_2683, 32'h0, 32'h0000_0080, 32'h0, 1'b0, 32'h0);
        sample();
        chk_ctl("rw_c1", 1'b1, 1'b1, 1'b0);
        next();
        sample();
        chk_ctl("rw_wait", 1'b1, 1'b1, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        chk_ctl("rw_async", 1'b0, 1'b0, 1'b0);
        chk("rw_wr", {31'h0, reg_wr}, 32'h0);
        next();
        rst = 1'b0;
        drive(32'h00A0_0293, 32'h0, 32'd77, 32'h0, 1'b0, 32'h0);
        sb_q.push_back(32'd77);
        sample();
        chk_ctl("rw_idle", 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
